store_buffer: RTL

Data-side memory stage sitting directly downstream of the pipelined ARM core's memory-access outputs (address `ALUResult`, `WriteData`, `MemWrite`). It decouples core stores from a slow data bus through a small FIFO store buffer. Loads are serviced by forwarding from buffered stores or by a bus read after the buffer drains. A `Stall` output freezes the core's pipeline while the buffer cannot accept or complete an access.

---
 rtl/store_buffer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer between the core's memory stage and a slow data bus.
// Define STORE_BUFFER_FWD_EN to let loads forward from buffered stores.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [AW-1:0]            ALUResult,
  input  logic [DW-1:0]            WriteData,
  output logic [DW-1:0]            ReadData,
  output logic                     Stall,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [AW-1:0]            bus_addr,
  output logic [DW-1:0]            bus_wdata,
  input  logic                     bus_ready,
  input  logic [DW-1:0]            bus_rdata,
  input  logic                     bus_rvalid,
  output logic [2:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int WA = AW - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_DONE = 3'd4
  } state_t;

  logic [WA-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  state_t        state, state_nxt;
  logic [WA-1:0] ld_addr;
  logic [DW-1:0] rd_q;

  logic          is_load, full, draining, pop, push, hit, load_miss;
  logic [DW-1:0] fwd_data;
  logic          unused_addr_lsbs;

  // Bus handshake: a transfer happens in a cycle where bus_req and bus_ready
  // are both high; bus_rvalid later returns read data once per read.
  assign is_load   = MemRead & ~MemWrite;
  assign full      = (count == (PW+1)'(DEPTH));
  assign draining  = ((state == IDLE) || (state == DRAIN)) && (count != '0);
  assign pop       = draining & bus_ready;
  assign push      = MemWrite && ((state == IDLE) || (state == RD_DONE)) && (!full || pop);
  assign load_miss = (state == IDLE) && is_load && !hit;

  assign unused_addr_lsbs = ^ALUResult[1:0];

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if (((PW+1)'(k) < count) && (q_addr[fwd_idx] == ALUResult[AW-1:2]) &&
          (state == IDLE) && is_load) begin
        hit      = 1'b1;
        fwd_data = q_data[fwd_idx];
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    ReadData  = rd_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (draining) begin
      bus_req   = 1'b1;
      bus_we    = 1'b1;
      bus_addr  = {q_addr[head], 2'b00};
      bus_wdata = q_data[head];
    end
    case (state)
      IDLE: begin
        if (MemWrite) begin
          Stall = full & ~pop;
        end else if (hit) begin
          ReadData = fwd_data;
        end else if (load_miss) begin
          // An already empty buffer has nothing to drain, so go straight to the read.
          Stall     = 1'b1;
          state_nxt = (count != '0) ? DRAIN : RD_REQ;
        end
      end
      DRAIN: begin
        Stall = 1'b1;
        if (count == '0) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        Stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = {ld_addr, 2'b00};
        bus_wdata = '0;
        if (bus_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        Stall = 1'b1;
        if (bus_rvalid) state_nxt = RD_DONE;
      end
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      state   <= IDLE;
      ld_addr <= '0;
      rd_q    <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      state <= state_nxt;
      if (load_miss) ld_addr <= ALUResult[AW-1:2];
      if ((state == RD_WAIT) && bus_rvalid) rd_q <= bus_rdata;
    end
  end

  // Entry storage needs no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= ALUResult[AW-1:2];
      q_data[tail] <= WriteData;
    end
  end

  assign dbg_state = state;
  assign dbg_count = count;

endmodule
